// File: rtl/sram_wb_pkg.sv
// rtl/sram_wb_pkg.sv - shared types, default widths and address decode for the SRAM Wishbone bridge
package sram_wb_pkg;

    localparam int          DEF_ADDR_WIDTH = 9;
    localparam int          DEF_DATA_WIDTH = 32;
    localparam int          DEF_NUM_WMASKS = 4;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h0100_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_ACK
    } port_state_e;

    // Only the bits above the word index and byte offset take part in the window match.
    function automatic logic addr_match(
        input logic [31:0] adr,
        input logic [31:0] base,
        input int unsigned aw
    );
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (aw + 2);
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/sram_wb_port.sv
// rtl/sram_wb_port.sv - one Wishbone-classic slave port driving one port of the SRAM macro
module sram_wb_port
    import sram_wb_pkg::*;
#(
    parameter bit          WRITABLE   = 1'b1,
    parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int          NUM_WMASKS = DEF_NUM_WMASKS,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc,
    input  logic                  stb,
    input  logic                  we,
    input  logic [NUM_WMASKS-1:0] sel,
    input  logic [31:0]           adr,
    input  logic [DATA_WIDTH-1:0] dat,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  csb,
    output logic                  web,
    output logic [NUM_WMASKS-1:0] wmask,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  wr_go
);

    port_state_e           state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  req;
    logic                  is_wr;
    logic                  go;

    always_comb begin
        req     = cyc & stb & addr_match(adr, BASE_ADDR, ADDR_WIDTH);
        is_wr   = WRITABLE ? we : 1'b0;
        go      = (state_q == ST_IDLE) & req & ~stall & ~rst;
        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = is_wr ? ST_ACK : ST_RD_WAIT;
                    ack_d   = is_wr;
                end
            end
            ST_RD_WAIT: begin
                dat_d   = sram_dout;
                state_d = ST_ACK;
                ack_d   = 1'b1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    // Macro pins are combinational so the macro latches the request on this cycle's edge.
    always_comb begin
        csb   = ~go;
        web   = ~(go & is_wr);
        wmask = go ? sel : '0;
        addr  = adr[ADDR_WIDTH+1:2];
        din   = dat;
        wr_go = go & is_wr;
    end

    assign ack   = ack_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/sram_wb_bridge_32x512.sv
// rtl/sram_wb_bridge_32x512.sv - dual Wishbone front end for the 512x32 one-RW one-R SRAM macro
module sram_wb_bridge_32x512
    import sram_wb_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int          NUM_WMASKS = DEF_NUM_WMASKS,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs0_cyc_i,
    input  logic                  wbs0_stb_i,
    input  logic                  wbs0_we_i,
    input  logic [NUM_WMASKS-1:0] wbs0_sel_i,
    input  logic [31:0]           wbs0_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs0_dat_i,
    output logic                  wbs0_ack_o,
    output logic [DATA_WIDTH-1:0] wbs0_dat_o,
    input  logic                  wbs1_cyc_i,
    input  logic                  wbs1_stb_i,
    input  logic [31:0]           wbs1_adr_i,
    output logic                  wbs1_ack_o,
    output logic [DATA_WIDTH-1:0] wbs1_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    logic                  p0_wr_go;
    logic                  p1_stall;
    logic                  p1_web;
    logic [NUM_WMASKS-1:0] p1_wmask;
    logic [DATA_WIDTH-1:0] p1_din;
    logic                  p1_wr_go;
    logic                  unused_p1;

    // Port 1 backs off for one cycle when it would read the word port 0 is writing right now.
    assign p1_stall  = p0_wr_go & (wbs1_adr_i[ADDR_WIDTH+1:2] == wbs0_adr_i[ADDR_WIDTH+1:2]);
    assign unused_p1 = ^{p1_web, p1_wmask, p1_din, p1_wr_go};

    sram_wb_port #(
        .WRITABLE   (1'b1),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WMASKS (NUM_WMASKS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_port0 (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .cyc       (wbs0_cyc_i),
        .stb       (wbs0_stb_i),
        .we        (wbs0_we_i),
        .sel       (wbs0_sel_i),
        .adr       (wbs0_adr_i),
        .dat       (wbs0_dat_i),
        .stall     (1'b0),
        .sram_dout (sram_dout0),
        .ack       (wbs0_ack_o),
        .dat_o     (wbs0_dat_o),
        .csb       (sram_csb0),
        .web       (sram_web0),
        .wmask     (sram_wmask0),
        .addr      (sram_addr0),
        .din       (sram_din0),
        .wr_go     (p0_wr_go)
    );

    sram_wb_port #(
        .WRITABLE   (1'b0),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WMASKS (NUM_WMASKS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_port1 (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .cyc       (wbs1_cyc_i),
        .stb       (wbs1_stb_i),
        .we        (1'b0),
        .sel       ('0),
        .adr       (wbs1_adr_i),
        .dat       ('0),
        .stall     (p1_stall),
        .sram_dout (sram_dout1),
        .ack       (wbs1_ack_o),
        .dat_o     (wbs1_dat_o),
        .csb       (sram_csb1),
        .web       (p1_web),
        .wmask     (p1_wmask),
        .addr      (sram_addr1),
        .din       (p1_din),
        .wr_go     (p1_wr_go)
    );

endmodule

// File: tb/tb_sram_wb_bridge_32x512.sv
// tb/tb_sram_wb_bridge_32x512.sv - scoreboard bench for the dual-port SRAM Wishbone bridge
module tb_sram_wb_bridge_32x512;

    localparam logic [31:0] BASE = 32'h0100_0000;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs0_cyc_i = 0, wbs0_stb_i = 0, wbs0_we_i = 0;
    logic [3:0]  wbs0_sel_i = 0;
    logic [31:0] wbs0_adr_i = 0, wbs0_dat_i = 0;
    logic        wbs0_ack_o;
    logic [31:0] wbs0_dat_o;
    logic        wbs1_cyc_i = 0, wbs1_stb_i = 0;
    logic [31:0] wbs1_adr_i = 0;
    logic        wbs1_ack_o;
    logic [31:0] wbs1_dat_o;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = 0, sram_dout1 = 0;

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic [31:0] ref_mem [512];
    logic [31:0] last0 = 0, last1 = 0;

    logic [31:0] mem [512];
    logic        l0_csb = 1, l0_web = 1, l1_csb = 1;
    logic [3:0]  l0_wmask = 0;
    logic [8:0]  l0_addr = 0, l1_addr = 0;
    logic [31:0] l0_din = 0;

    sram_wb_bridge_32x512 dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs0_cyc_i  (wbs0_cyc_i),
        .wbs0_stb_i  (wbs0_stb_i),
        .wbs0_we_i   (wbs0_we_i),
        .wbs0_sel_i  (wbs0_sel_i),
        .wbs0_adr_i  (wbs0_adr_i),
        .wbs0_dat_i  (wbs0_dat_i),
        .wbs0_ack_o  (wbs0_ack_o),
        .wbs0_dat_o  (wbs0_dat_o),
        .wbs1_cyc_i  (wbs1_cyc_i),
        .wbs1_stb_i  (wbs1_stb_i),
        .wbs1_adr_i  (wbs1_adr_i),
        .wbs1_ack_o  (wbs1_ack_o),
        .wbs1_dat_o  (wbs1_dat_o),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Macro model: inputs latched on the rising edge, array access on the falling edge.
    always @(posedge clk) begin
        l0_csb   <= sram_csb0;
        l0_web   <= sram_web0;
        l0_wmask <= sram_wmask0;
        l0_addr  <= sram_addr0;
        l0_din   <= sram_din0;
        l1_csb   <= sram_csb1;
        l1_addr  <= sram_addr1;
    end

    always @(negedge clk) begin
        if (!l0_csb && !l0_web)
            for (int b = 0; b < 4; b++)
                if (l0_wmask[b]) mem[l0_addr][8*b +: 8] = l0_din[8*b +: 8];
        if (!l0_csb && l0_web) sram_dout0 = mem[l0_addr];
        if (!l1_csb) sram_dout1 = mem[l1_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wbs0_ack_o) begin
            if (q0.size() == 0) check_eq("p0_spurious_ack", 1, 0);
            else begin
                e0 = q0.pop_front();
                check_eq("p0_ack_cycle", cyc_cnt, e0.cyc);
                check_eq("p0_dat", wbs0_dat_o, e0.dat);
            end
        end
        if (wbs1_ack_o) begin
            if (q1.size() == 0) check_eq("p1_spurious_ack", 1, 0);
            else begin
                e1 = q1.pop_front();
                check_eq("p1_ack_cycle", cyc_cnt, e1.cyc);
                check_eq("p1_dat", wbs1_dat_o, e1.dat);
            end
        end
    end

    task automatic p0_start(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat);
        exp_t e;
        int   idx;
        idx        = int'(adr[10:2]);
        wbs0_cyc_i = 1;
        wbs0_stb_i = 1;
        wbs0_we_i  = we;
        wbs0_sel_i = sel;
        wbs0_adr_i = adr;
        wbs0_dat_i = dat;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
            e.dat = last0;
            e.cyc = cyc_cnt + 1;
        end else begin
            e.dat = ref_mem[idx];
            last0 = e.dat;
            e.cyc = cyc_cnt + 2;
        end
        q0.push_back(e);
    endtask

    task automatic p1_start(input logic [31:0] adr);
        exp_t e;
        logic haz;
        haz = wbs0_cyc_i && wbs0_stb_i && wbs0_we_i && (wbs0_adr_i[31:11] == BASE[31:11])
              && (wbs0_adr_i[10:2] == adr[10:2]);
        wbs1_cyc_i = 1;
        wbs1_stb_i = 1;
        wbs1_adr_i = adr;
        e.dat = ref_mem[int'(adr[10:2])];
        last1 = e.dat;
        e.cyc = cyc_cnt + (haz ? 3 : 2);
        q1.push_back(e);
    endtask

    task automatic p0_wait();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wbs0_ack_o && n < 8);
        if (!wbs0_ack_o) check_eq("p0_ack_timeout", 0, 1);
        wbs0_cyc_i = 0;
        wbs0_stb_i = 0;
        wbs0_we_i  = 0;
    endtask

    task automatic p1_wait();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wbs1_ack_o && n < 8);
        if (!wbs1_ack_o) check_eq("p1_ack_timeout", 0, 1);
        wbs1_cyc_i = 0;
        wbs1_stb_i = 0;
    endtask

    task automatic p0_op(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat);
        @(posedge clk); #1;
        p0_start(we, sel, adr, dat);
        p0_wait();
    endtask

    task automatic dual(input logic we, input logic [3:0] sel, input logic [31:0] adr0,
                        input logic [31:0] dat, input logic [31:0] adr1);
        @(posedge clk); #1;
        p0_start(we, sel, adr0, dat);
        p1_start(adr1);
        fork
            p0_wait();
            p1_wait();
        join
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ack0", wbs0_ack_o, 0);
        check_eq("rst_ack1", wbs1_ack_o, 0);
        check_eq("rst_dat0", wbs0_dat_o, 0);
        check_eq("rst_dat1", wbs1_dat_o, 0);
        check_eq("rst_csb0", sram_csb0, 1);
        check_eq("rst_csb1", sram_csb1, 1);
        check_eq("rst_web0", sram_web0, 1);
        check_eq("rst_wmask0", sram_wmask0, 0);
        @(posedge clk); #1;
        rst = 0;

        // Full write with pin check, then read back through a misaligned byte address.
        @(posedge clk); #1;
        p0_start(1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
        #1;
        check_eq("wr_csb0", sram_csb0, 0);
        check_eq("wr_web0", sram_web0, 0);
        check_eq("wr_wmask0", sram_wmask0, 4'hF);
        check_eq("wr_addr0", sram_addr0, 9'h4);
        p0_wait();
        p0_op(0, 4'hF, BASE + 32'h13, 32'h0);

        // Byte lanes 0 and 2 only.
        p0_op(1, 4'hF, BASE + 32'h20, 32'h1122_3344);
        p0_op(1, 4'b0101, BASE + 32'h20, 32'hAABB_CCDD);
        p0_op(0, 4'h0, BASE + 32'h20, 32'h0);

        // Empty byte mask still acks and leaves the word alone.
        p0_op(1, 4'h0, BASE + 32'h10, 32'hFFFF_FFFF);
        p0_op(0, 4'h3, BASE + 32'h10, 32'h0);

        // Same-word write/read collision, then disjoint concurrent reads.
        dual(1, 4'hF, BASE + 32'h40, 32'h5A5A_5A5A, BASE + 32'h40);
        dual(0, 4'hF, BASE + 32'h10, 32'h0, BASE + 32'h20);

        // Outside the window: no ack and no chip select.
        @(posedge clk); #1;
        wbs0_cyc_i = 1;
        wbs0_stb_i = 1;
        wbs0_we_i  = 1;
        wbs0_adr_i = BASE + 32'h1000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("oow_csb0", sram_csb0, 1);
        end
        @(posedge clk); #1;
        wbs0_cyc_i = 0;
        wbs0_stb_i = 0;
        wbs0_we_i  = 0;

        // Reset while port 0 is in RD_WAIT.
        @(posedge clk); #1;
        wbs0_cyc_i = 1;
        wbs0_stb_i = 1;
        wbs0_we_i  = 0;
        wbs0_adr_i = BASE + 32'h10;
        @(posedge clk); #1;
        rst        = 1;
        wbs0_cyc_i = 0;
        wbs0_stb_i = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_eq("rstmid_ack0", wbs0_ack_o, 0);
        check_eq("rstmid_dat0", wbs0_dat_o, 0);
        check_eq("rstmid_dat1", wbs1_dat_o, 0);
        check_eq("rstmid_csb0", sram_csb0, 1);
        last0 = 0;
        last1 = 0;
        repeat (3) @(posedge clk);
        dual(0, 4'hF, BASE + 32'h20, 32'h0, BASE + 32'h13);

        for (int i = 0; i < 12; i++)
            dual($urandom_range(0, 1), 4'($urandom_range(0, 15)),
                 BASE + 32'($urandom_range(0, 7) * 4), $urandom,
                 BASE + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)));

        repeat (5) @(posedge clk);
        check_eq("p0_pending", q0.size(), 0);
        check_eq("p1_pending", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
